vga_ctrl_pipe: RTL and testbench

Parametrised successor to the current VGA controller. It generates 640x480-class timing from generic porch/sync parameters and drives a pixel-address/read-enable front end for a synchronous frame buffer of configurable read latency. Syncs and blanking are delayed so they stay aligned with returned pixel data. A frame-latched mode register selects frame-buffer, colour-bar, grid or solid-fill output. The block sits between the video memory and the VGA_* pins in top.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_ctrl_pipe_if.sv | 16 +
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_ctrl_pipe.sv | 167 ++++++++++++++++
 tb/tb_vga_ctrl_pipe.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the pipelined VGA controller.
//   vga_mode_e   : output source select (frame buffer, bars, grid, solid fill)
//   RGB_W        : packed {R,G,B} pixel width
//   BAR_*        : colour-bar palette, left to right
//   vga_stage_t  : bundle carried through the read-latency delay line
package vga_pkg;

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    MODE_FB    = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } vga_mode_e;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // hs/vs are raw "in sync window" flags (active high); polarity is applied
  // only at the pins so a cleared stage always means inactive syncs.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vis;
    logic             frame;
    logic             use_fb;
    logic [RGB_W-1:0] pat;
  } vga_stage_t;

endpackage

// File: rtl/vga_ctrl_pipe_if.sv
// Frame-buffer read bus between the VGA controller and video memory.
//   h_addr, v_addr : pixel address (0 outside the active area)
//   rd_en          : address is a visible pixel
//   vga_data       : pixel returned RD_LAT clocks after rd_en
// master = controller side, slave = memory side.
interface vga_ctrl_pipe_if;
  import vga_pkg::*;

  logic [9:0]       h_addr;
  logic [9:0]       v_addr;
  logic             rd_en;
  logic [RGB_W-1:0] vga_data;

  modport master (output h_addr, output v_addr, output rd_en, input vga_data);
  modport slave  (input h_addr, input v_addr, input rd_en, output vga_data);
endinterface

// File: rtl/vga_delay_line.sv
// Depth-N shift register for a W-bit bus with asynchronous active-low clear.
// N = 0 degenerates to a wire.
//   clk, resetn : clock, async clear (all stages to 0)
//   d, q        : bus in, bus out delayed N clocks
module vga_delay_line #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_wire
      assign q = d;
    end else begin : g_regs
      logic [W-1:0] sr [N];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int unsigned i = 0; i < N; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int unsigned i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_ctrl_pipe.sv
// Pipelined VGA timing generator with frame-buffer read front end.
//   clk, resetn  : pixel clock, async active-low reset
//   en           : run enable (0 holds counters at 0 and blanks)
//   mode         : 0 frame buffer, 1 colour bars, 2 grid, 3 solid
//   solid_rgb    : fill colour for mode 3
//   fb           : frame-buffer read bus (h_addr, v_addr, rd_en, vga_data)
//   hsync, vsync : sync pins, polarity from HSYNC_POL / VSYNC_POL
//   valid        : blanking negated
//   vga_r/g/b    : pixel colour
//   frame_start  : one-clock pulse alongside output pixel (0,0)
// Outputs lag the counters by RD_LAT+1 clocks so syncs/blank line up with
// the memory data returned for the same pixel.
module vga_ctrl_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] solid_rgb,
  vga_ctrl_pipe_if.master  fb,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b,
  output logic             frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

  logic [9:0]       hc, vc;
  logic [9:0]       bar_pos;
  logic [2:0]       bar_idx;
  vga_mode_e        mode_act;
  logic [RGB_W-1:0] solid_act;

  logic             frame0;
  logic             visible;
  vga_mode_e        mode_cur;
  logic [RGB_W-1:0] solid_cur;
  vga_stage_t       s0, sd;
  logic [RGB_W-1:0] rgb_q;

  // Bar position runs alongside hc so the bar index needs no divider.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hc      <= '0;
      vc      <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!en) begin
      hc      <= '0;
      vc      <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (hc == H_LAST) begin
      hc      <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
      vc      <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
      if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 10'd1;
      end
    end
  end

  assign frame0  = en && (hc == '0) && (vc == '0);
  assign visible = en && (hc < H_ACT_C) && (vc < V_ACT_C);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_act  <= MODE_FB;
      solid_act <= '0;
    end else if (frame0) begin
      mode_act  <= vga_mode_e'(mode);
      solid_act <= solid_rgb;
    end
  end

  // Pixel (0,0) already belongs to the newly latched mode, so bypass the
  // register on the latching cycle.
  assign mode_cur  = frame0 ? vga_mode_e'(mode) : mode_act;
  assign solid_cur = frame0 ? solid_rgb : solid_act;

  always_comb begin
    fb.h_addr = visible ? hc : '0;
    fb.v_addr = visible ? vc : '0;
    fb.rd_en  = visible;

    s0        = '0;
    s0.hs     = en && (hc >= HS_BEG) && (hc < HS_END);
    s0.vs     = en && (vc >= VS_BEG) && (vc < VS_END);
    s0.vis    = visible;
    s0.frame  = frame0;
    s0.use_fb = (mode_cur == MODE_FB);
    case (mode_cur)
      MODE_BARS:  s0.pat = bar_colour(bar_idx);
      MODE_GRID:  s0.pat = ((hc[3:0] == 4'd0) || (vc[3:0] == 4'd0)) ? '1 : '0;
      MODE_SOLID: s0.pat = solid_cur;
      default:    s0.pat = '0;
    endcase
  end

  vga_delay_line #(
    .N ($bits(vga_stage_t) > 0 ? RD_LAT : 0),
    .W ($bits(vga_stage_t))
  ) u_delay (
    .clk    (clk),
    .resetn (resetn),
    .d      (s0),
    .q      (sd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hsync       <= sd.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= sd.vs ? VSYNC_POL : ~VSYNC_POL;
      valid       <= sd.vis;
      frame_start <= sd.frame;
      if (!sd.vis)
        rgb_q <= '0;
      else if (sd.use_fb)
        rgb_q <= fb.vga_data;
      else
        rgb_q <= sd.pat;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule

// File: tb/tb_vga_ctrl_pipe.sv
// Self-checking bench for vga_ctrl_pipe using reduced timing (80x30 totals)
// and RD_LAT=2. The reference model tracks a linear pixel index per frame and
// derives every expected output from it with plain arithmetic.
module tb_vga_ctrl_pipe;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int L = 2;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;

  typedef struct packed {
    bit          hs;
    bit          vs;
    bit          vis;
    bit          fr;
    logic [23:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = '0;
  logic        hsync, vsync, valid, frame_start;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_ctrl_pipe_if fb_if ();

  vga_ctrl_pipe #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .RD_LAT (L)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .fb          (fb_if),
    .hsync       (hsync),
    .vsync       (vsync),
    .valid       (valid),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous memory with 2-clock latency; unread cycles return junk.
  logic [23:0] mem_d1 = '0, mem_d2 = '0;
  always @(posedge clk) begin
    mem_d1 <= fb_if.rd_en ? {fb_if.h_addr[7:0], fb_if.v_addr[7:0], 8'h5A} : 24'($urandom);
    mem_d2 <= mem_d1;
  end
  assign fb_if.vga_data = mem_d2;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          checks = 0;
  int          errors = 0;
  int          cnt = 0;
  int          lat_mode = 0;
  logic [23:0] lat_solid = '0;
  pix_t        pipe [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cnt=%0d)", tag, obs, exp, cnt);
    end
  endtask

  function automatic logic [23:0] colour(input int hc, input int vc, input int m,
                                         input logic [23:0] sol);
    case (m)
      0:       return {8'(hc), 8'(vc), 8'h5A};
      1:       return bar_tab[hc / (HA / 8)];
      2:       return ((hc % 16 == 0) || (vc % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return sol;
    endcase
  endfunction

  task automatic model_reset();
    pix_t blank;
    blank = '0;
    cnt = 0;
    lat_mode = 0;
    lat_solid = '0;
    pipe.delete();
    for (int i = 0; i < L; i++) pipe.push_back(blank);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_hsync", hsync, !HPOL);
    chk("rst_vsync", vsync, !VPOL);
    chk("rst_valid", valid, 0);
    chk("rst_frame", frame_start, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_h_addr", fb_if.h_addr, 0);
    chk("rst_v_addr", fb_if.v_addr, 0);
    chk("rst_rd_en", fb_if.rd_en, en);
  endtask

  // One pixel clock: check stage-0 outputs, predict, cross the edge,
  // then check registered outputs against the delayed prediction.
  task automatic tick();
    pix_t s, e;
    int   hc, vc;
    bit   vis;
    #1;
    hc  = cnt % HT;
    vc  = cnt / HT;
    vis = en && hc < HA && vc < VA;
    chk("h_addr", fb_if.h_addr, vis ? hc : 0);
    chk("v_addr", fb_if.v_addr, vis ? vc : 0);
    chk("rd_en", fb_if.rd_en, vis);
    s.fr = en && cnt == 0;
    if (s.fr) begin
      lat_mode  = mode;
      lat_solid = solid_rgb;
    end
    s.hs  = en && hc >= HA + HFP && hc < HA + HFP + HSW;
    s.vs  = en && vc >= VA + VFP && vc < VA + VFP + VSW;
    s.vis = vis;
    s.rgb = vis ? colour(hc, vc, lat_mode, lat_solid) : 24'h0;
    @(posedge clk);
    pipe.push_back(s);
    e   = pipe.pop_front();
    cnt = en ? (cnt + 1) % FRAME : 0;
    #1;
    chk("hsync", hsync, e.hs ? HPOL : !HPOL);
    chk("vsync", vsync, e.vs ? VPOL : !VPOL);
    chk("valid", valid, e.vis);
    chk("frame_start", frame_start, e.fr);
    chk("rgb", {vga_r, vga_g, vga_b}, e.rgb);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int target);
    for (int g = 0; g <= FRAME && cnt != target; g++) tick();
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    en = 1'b1;
    #1 resetn = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    model_reset();

    // Free-running frame-buffer timing over two frames.
    ticks(2 * FRAME + 10);

    // Solid fill requested mid-frame: applies from the next frame only.
    run_until(10 * HT);
    mode = 2'd3;
    solid_rgb = 24'h123456;
    ticks(2 * FRAME);

    // Each pattern in turn, switched at random points mid-frame.
    mode = 2'd1; ticks($urandom_range(1, FRAME - 1)); ticks(FRAME);
    mode = 2'd2; ticks($urandom_range(1, FRAME - 1)); ticks(FRAME);
    mode = 2'd0; ticks($urandom_range(1, FRAME - 1)); ticks(FRAME);
    for (int k = 0; k < 3; k++) begin
      mode = 2'($urandom_range(0, 3));
      solid_rgb = 24'($urandom);
      ticks($urandom_range(1, FRAME - 1));
      ticks(FRAME);
    end

    // Asynchronous reset mid-line.
    mode = 2'd1;
    run_until(10 * HT + 30);
    pulse_reset();
    ticks(FRAME + 10);

    // Reset at a random point.
    ticks($urandom_range(1, FRAME - 1));
    pulse_reset();
    ticks(L + 5);

    // Enable dropped then restored.
    mode = 2'd0;
    ticks($urandom_range(100, 900));
    en = 1'b0;
    ticks($urandom_range(300, 1000));
    en = 1'b1;
    ticks(FRAME + 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
